// File: rtl/f1_start_ctrl_pkg.sv
// Shared types and constants for the F1 start-light sequencer and its LFSR.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int                LFSR_W    = 7;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

    // x^7 + x^3 + 1, maximal length (127); the all-zero state is unreachable from the seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[5:0], cur[6] ^ cur[2]};
    endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Control/status bundle between the start-light sequencer and its surroundings.
interface f1_start_ctrl_if
    import f1_pkg::*;
#(
    parameter int N_LIGHTS = 8
) ();

    logic                trigger;
    logic                abort;
    logic [N_LIGHTS-1:0] lights;
    logic                busy;
    logic                go;
    logic [LFSR_W-1:0]   delay_val;

    modport master (
        output trigger,
        output abort,
        input  lights,
        input  busy,
        input  go,
        input  delay_val
    );

    modport slave (
        input  trigger,
        input  abort,
        output lights,
        output busy,
        output go,
        output delay_val
    );

endinterface

// File: rtl/f1_start_ctrl_lfsr.sv
// Free-running 7-bit Fibonacci LFSR used as the random hold-time source.
module rand_lfsr7
    import f1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    // Shift register state; advances one step per enabled clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// Start-light sequencer: lights lamps one per tick, holds for a random number
// of ticks, then blanks the lamps and pulses go for one cycle.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int TICK_DIV = 48,
    parameter int N_LIGHTS = 8
) (
    input logic            clk,
    input logic            rst_n,
    f1_start_ctrl_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t              state_r;
    logic [TW-1:0]       tick_cnt_r;
    logic [LFSR_W-1:0]   delay_cnt_r;
    logic [N_LIGHTS-1:0] lights_r;
    logic                busy_r;
    logic                go_r;
    logic [LFSR_W-1:0]   delay_val_r;

    logic [LFSR_W-1:0]   lfsr_q_s;
    logic                tick_s;
    logic [N_LIGHTS-1:0] lights_shift_s;

    rand_lfsr7 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q_s)
    );

    assign tick_s         = (tick_cnt_r == TW'(TICK_DIV - 1));
    // Thermometer fill from bit 0; the top bit of the shifted result marks the last lamp.
    assign lights_shift_s = N_LIGHTS'({lights_r, 1'b1});

    // Sequencer FSM with tick divider, hold counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            tick_cnt_r  <= '0;
            delay_cnt_r <= 7'd0;
            lights_r    <= '0;
            busy_r      <= 1'b0;
            go_r        <= 1'b0;
            delay_val_r <= 7'd0;
        end else if (bus.abort) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            lights_r   <= '0;
            busy_r     <= 1'b0;
            go_r       <= 1'b0;
        end else begin
            go_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    lights_r   <= '0;
                    tick_cnt_r <= '0;
                    // busy stays up through the go cycle and drops here unless restarted
                    if (bus.trigger) begin
                        state_r <= LIGHTS;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                LIGHTS: begin
                    busy_r <= 1'b1;
                    if (tick_s) begin
                        tick_cnt_r <= '0;
                        lights_r   <= lights_shift_s;
                        if (lights_shift_s[N_LIGHTS-1]) begin
                            state_r     <= HOLD;
                            delay_cnt_r <= lfsr_q_s;
                            delay_val_r <= lfsr_q_s;
                        end else begin
                            state_r <= LIGHTS;
                        end
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                HOLD: begin
                    busy_r <= 1'b1;
                    if (tick_s) begin
                        tick_cnt_r <= '0;
                        if (delay_cnt_r == 7'd1) begin
                            lights_r <= '0;
                            go_r     <= 1'b1;
                            state_r  <= IDLE;
                        end else begin
                            delay_cnt_r <= delay_cnt_r - 7'd1;
                        end
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tick_cnt_r <= '0;
                    lights_r   <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lights    = lights_r;
    assign bus.busy      = busy_r;
    assign bus.go        = go_r;
    assign bus.delay_val = delay_val_r;

endmodule

// File: doc/f1_start_ctrl.md
# f1_start_ctrl

Start-light sequencer that drives a 7-bit LFSR random source. On a trigger it lights `N_LIGHTS` lamps one per tick. It then holds all lamps lit for a random number of ticks taken from the LFSR, turns them off, and issues a one-cycle `go` pulse. It sits between the top-level button/clock logic and the lamp outputs, and owns the LFSR instance, its enable and its seed.

## Interface
- `TICK_DIV`, default 48 — clock cycles per sequencing tick; must be ≥1.
- `N_LIGHTS`, default 8 — number of lamps; must be ≥1.

- `clk`  in  1  — single system clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `trigger`  in  1  — start request; sampled on `clk` edges; acted on only in IDLE.
- `abort`  in  1  — synchronous cancel; effective in every state.
- `lights`  out  N_LIGHTS  — lamp drive, thermometer-coded from bit 0.
- `busy`  out  1  — high whenever state ≠ IDLE.
- `go`  out  1  — one-cycle pulse when the lamps go out.
- `delay_val`  out  7  — last sampled random delay in ticks; for the scoreboard.

## Operation
- Reset values: state IDLE, `lights`=0, `busy`=0, `go`=0, `delay_val`=0, tick counter=0, LFSR=7'h01.
- LFSR:
  - Free-runs, advancing every clock edge with enable tied high.
  - Next state is {q[5:0], q[6]^q[2]}, i.e. x^7+x^3+1, period 127.
  - It never holds 0.
  - The sequence after reset is 01, 02, 04, 09, 12, 24, 49, 13, …
- Tick counter:
  - Counts 0..TICK_DIV-1 only while in LIGHTS or HOLD.
  - Forced to 0 on every entry to LIGHTS.
  - tick = (count == TICK_DIV-1).
- IDLE:
  - `lights`=0.
  - trigger=1 and abort=0 → go to LIGHTS.
- LIGHTS:
  - On each tick, `lights` ← {lights[N-2:0], 1'b1}.
  - On the tick that sets lights[N_LIGHTS-1], go to HOLD and load the current (pre-edge) LFSR value into both delay_cnt and `delay_val`.
- HOLD:
  - Each tick decrements delay_cnt.
  - On a tick with delay_cnt==1: `lights` ← 0, `go` ← 1, go to IDLE.
- `go`: high for exactly one cycle, then 0.
- `trigger`: ignored outside IDLE. A trigger held high through the return to IDLE restarts the sequence on the next edge. This is legal and required.
- `abort`:
  - From any state, the next edge gives IDLE, `lights`=0, `go`=0, tick counter=0.
  - `delay_val` keeps its value.
  - abort and trigger together in IDLE → stay in IDLE.
- Mid-sequence `rst_n` assertion: all outputs return to reset values immediately (asynchronously).
- delay_cnt is 7 bits wide; loaded values are 1..127. No wrap is possible because the counter stops at 1.

## Timing
- trigger sampled at edge t:
  - `busy` is high after edge t.
  - lights[k] is set at edge t+(k+1)·TICK_DIV.
  - All lamps are lit at edge t+N_LIGHTS·TICK_DIV.
- With D = `delay_val`: lamps clear and `go` rises at edge t+(N_LIGHTS+D)·TICK_DIV. `go` and `busy` fall at the following edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `f1_pkg`:
  - state enum: IDLE, LIGHTS, HOLD.
  - LFSR width constant (7).
  - Reset seed 7'h01.
- One sub-module, `rand_lfsr7`: 7-bit LFSR with clk, rst_n, en, q, using the taps above and async active-low reset to the seed.
- The FSM, tick counter and delay counter stay in `f1_start_ctrl`.

## Test plan
- Reset: hold rst_n=0 → `lights`=0, `busy`=0, `go`=0, `delay_val`=0. After release, LFSR reads 01, 02, 04, 09 on successive edges.
- Full sequence (TICK_DIV=1, N_LIGHTS=2), trigger sampled at the first edge after release (edge 1):
  - lights=01 at edge 2, lights=11 at edge 3.
  - `delay_val`=4.
  - lights=00 and `go`=1 at edge 7; `go`=0 and `busy`=0 at edge 8.
- Tick spacing (TICK_DIV=4, N_LIGHTS=8): each lamp is added exactly 4 cycles apart, and lights reaches 8'hFF 32 cycles after the trigger edge.
- Abort during HOLD → IDLE next edge, `lights`=0, no `go` pulse, `delay_val` unchanged. A new trigger then restarts from lights=0.
- Trigger pulses during LIGHTS and HOLD → no effect on lamp timing. Simultaneous abort+trigger in IDLE → `busy` stays 0.
- Async reset mid-LIGHTS (lights=8'h07) → outputs clear within the same cycle with no clock edge. LFSR is back to 01.
